riscv_fetch_queue: RTL

- Parametrised instruction-prefetch front end that replaces the hart's single-entry pc/instr fetch register.
- Generates sequential fetch addresses and accepts icache responses into a DEPTH-entry FIFO of {pc, instr, fault}.
- Presents the FIFO head to decode with a valid/ready handshake.
- Flushes and re-steers on redirect (jump, trap, mret); flags misaligned targets as fetch faults.

---
 rtl/riscv_fetch_queue_if.sv | 31 +++
 rtl/riscv_fetch_queue.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_queue_if.sv
// Fetch-queue bus: redirect, icache request/response and decode handshake.
// The master modport is the fetch queue; the slave side is its environment.
interface riscv_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            icache_addr_valid;
  logic [XLEN-1:0] icache_addr;
  logic            icache_data_ready;
  logic [XLEN-1:0] icache_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_fault;
  logic [LW-1:0]   level;

  modport master (
    input  redirect_valid, redirect_pc, icache_data_ready, icache_data, out_ready,
    output icache_addr_valid, icache_addr, out_valid, out_pc, out_instr, out_fault, level
  );

  modport slave (
    output redirect_valid, redirect_pc, icache_data_ready, icache_data, out_ready,
    input  icache_addr_valid, icache_addr, out_valid, out_pc, out_instr, out_fault, level
  );
endinterface

// File: rtl/riscv_fetch_queue.sv
// Instruction prefetch queue: sequential fetch into a DEPTH-entry FIFO with redirect flush.
// Optional zero-latency bypass of an empty queue under macro RISCV_FETCHQ_BYPASS_EN.
module riscv_fetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h13)
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_fetch_queue_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   level_q, level_d;

  logic [XLEN-1:0] mem_pc_q    [DEPTH];
  logic [XLEN-1:0] mem_instr_q [DEPTH];
  logic            mem_fault_q [DEPTH];

  logic            full, aligned, addr_valid, accept, fifo_valid, bypass, push, pop;
  logic [XLEN-1:0] addr;
  logic            wr_en, wr_fault;
  logic [PW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_pc, wr_instr;

  always_comb begin
    full    = (level_q == LW'(DEPTH));
    aligned = (bus.redirect_pc[1:0] == 2'b00);
    addr    = bus.redirect_valid ? bus.redirect_pc : fetch_pc_q;
    if (bus.redirect_valid) addr_valid = aligned;
    else                    addr_valid = (state_q == ST_RUN) && !full;
    accept     = addr_valid && bus.icache_data_ready;
    fifo_valid = (level_q != '0);
`ifdef RISCV_FETCHQ_BYPASS_EN
    bypass = !fifo_valid && !bus.redirect_valid && accept;
`else
    bypass = 1'b0;
`endif
    pop  = fifo_valid && bus.out_ready;
    push = accept && !(bypass && bus.out_ready);
  end

  assign bus.icache_addr_valid = addr_valid;
  assign bus.icache_addr       = addr;
  assign bus.level             = level_q;

  // Head fields are forced to zero when nothing is valid, so reset and empty look identical.
  always_comb begin
    bus.out_valid = fifo_valid || bypass;
    bus.out_pc    = '0;
    bus.out_instr = '0;
    bus.out_fault = 1'b0;
    if (bypass) begin
      bus.out_pc    = addr;
      bus.out_instr = bus.icache_data;
    end else if (fifo_valid) begin
      bus.out_pc    = mem_pc_q[rd_ptr_q];
      bus.out_instr = mem_instr_q[rd_ptr_q];
      bus.out_fault = mem_fault_q[rd_ptr_q];
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    wr_en      = 1'b0;
    wr_idx     = wr_ptr_q;
    wr_pc      = addr;
    wr_instr   = bus.icache_data;
    wr_fault   = 1'b0;
    if (bus.redirect_valid) begin
      // Flush restarts both pointers at zero; any same-cycle write lands in slot 0.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      wr_idx   = '0;
      if (aligned) begin
        state_d    = ST_RUN;
        fetch_pc_d = accept ? addr + XLEN'(4) : bus.redirect_pc;
        if (accept) begin
          wr_en    = 1'b1;
          wr_ptr_d = PW'(1);
          level_d  = LW'(1);
        end
      end else begin
        state_d  = ST_HALT;
        wr_en    = 1'b1;
        wr_pc    = bus.redirect_pc;
        wr_instr = NOP_INSTR;
        wr_fault = 1'b1;
        wr_ptr_d = PW'(1);
        level_d  = LW'(1);
      end
    end else begin
      if (accept) fetch_pc_d = addr + XLEN'(4);
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc_q[wr_idx]    <= wr_pc;
      mem_instr_q[wr_idx] <= wr_instr;
      mem_fault_q[wr_idx] <= wr_fault;
    end
  end
endmodule
